// File: rtl/gat_pkg.sv
// Shared definitions for the GAT feature readout path: FSM states, stream
// geometry and feature-BRAM sizing.
package gat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } gat_state_t;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
    localparam int BEAT_BYTES  = 4;

    localparam int DEF_NUM_SUBGRAPHS     = 2708;
    localparam int DEF_NUM_FEATURE_OUT   = 16;
    localparam int DEF_NEW_FEATURE_DEPTH = DEF_NUM_SUBGRAPHS * DEF_NUM_FEATURE_OUT;

    function automatic int feat_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_NEW_FEATURE_ADDR_W = feat_addr_w(DEF_NEW_FEATURE_DEPTH);

endpackage

// File: rtl/gat_byte_fifo.sv
// Byte FIFO between the BRAM read pipe and the beat packer: one push per
// cycle, up to BEAT_BYTES pops per cycle, with a look-ahead window.
module gat_byte_fifo
    import gat_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  FIFO_DEPTH = 8,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_push,
    input  logic [DATA_WIDTH-1:0]                 i_push_data,
    input  logic [2:0]                            i_pop_n,
    output logic [BEAT_BYTES-1:0][DATA_WIDTH-1:0] o_peek,
    output logic [CNT_W-1:0]                      o_count
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // NOTE: storage is not reset; pointers and count alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop_n);
            r_count  <= r_count + CNT_W'(i_push) - CNT_W'(i_pop_n);
        end
    end

    always_comb begin
        for (int k = 0; k < BEAT_BYTES; k++) begin
            o_peek[k] = r_mem[r_rd_ptr + PTR_W'(k)];
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/gat_feat_stream_out.sv
// Sweeps the new-feature BRAM after the GAT core finishes and streams the
// bytes out as little-endian 32-bit AXI4-Stream beats with tlast/done.
module gat_feat_stream_out
    import gat_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_SUBGRAPHS      = DEF_NUM_SUBGRAPHS,
    parameter int NUM_FEATURE_OUT    = DEF_NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = feat_addr_w(NEW_FEATURE_DEPTH),
    parameter int RD_LATENCY         = 1,
    parameter int FIFO_DEPTH         = 8,
    parameter int AXIS_W             = AXIS_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
    input  logic [DATA_WIDTH-1:0]         feat_bram_dout,
    output logic [AXIS_W-1:0]             m_axis_tdata,
    output logic [AXIS_W/8-1:0]           m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          busy,
    output logic                          done
);

    localparam int LEFT_W = NEW_FEATURE_ADDR_W + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int KEEP_W = AXIS_W / 8;

    gat_state_t                    r_state;
    logic [NEW_FEATURE_ADDR_W-1:0] r_addr;
    logic [RD_LATENCY-1:0]         r_rd_vld;
    logic [LEFT_W-1:0]             r_bytes_left;
    logic [AXIS_W-1:0]             r_tdata;
    logic [KEEP_W-1:0]             r_tkeep;
    logic                          r_tlast;
    logic                          r_tvalid;
    logic                          r_busy;
    logic                          r_done;

    logic [CNT_W-1:0]                      w_fifo_count;
    logic [CNT_W-1:0]                      w_inflight;
    logic [CNT_W:0]                        w_occupancy;
    logic [BEAT_BYTES-1:0][DATA_WIDTH-1:0] w_peek;
    logic                                  w_issue;
    logic                                  w_last_addr;
    logic                                  w_push;
    logic                                  w_out_free;
    logic                                  w_load;
    logic                                  w_last_hs;
    logic [2:0]                            w_pop_req;
    logic [2:0]                            w_pop_n;
    logic [AXIS_W-1:0]                     w_beat_data;
    logic [KEEP_W-1:0]                     w_beat_keep;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_rd_vld[i]);
        end
    end

    // Credit: a read is only issued if its byte is guaranteed a FIFO slot.
    assign w_occupancy = {1'b0, w_fifo_count} + {1'b0, w_inflight};
    assign w_issue     = (r_state == ST_FETCH) && (w_occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign w_last_addr = (r_addr == NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1));
    assign w_push      = r_rd_vld[RD_LATENCY-1];

    assign w_out_free = !r_tvalid || m_axis_tready;
    assign w_pop_req  = (r_bytes_left >= LEFT_W'(BEAT_BYTES)) ? 3'(BEAT_BYTES) : r_bytes_left[2:0];
    assign w_load     = w_out_free && (r_bytes_left != '0) && (w_fifo_count >= CNT_W'(w_pop_req));
    assign w_pop_n    = w_load ? w_pop_req : 3'd0;
    assign w_last_hs  = r_tvalid && m_axis_tready && r_tlast;

    // NOTE: every signal gets a default before the loop so no path infers a latch.
    always_comb begin
        w_beat_data = '0;
        w_beat_keep = '0;
        for (int k = 0; k < BEAT_BYTES; k++) begin
            if (3'(k) < w_pop_req) begin
                w_beat_data[k*DATA_WIDTH +: DATA_WIDTH] = w_peek[k];
                w_beat_keep[k]                          = 1'b1;
            end
        end
    end

    gat_byte_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (feat_bram_dout),
        .i_pop_n     (w_pop_n),
        .o_peek      (w_peek),
        .o_count     (w_fifo_count)
    );

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (w_issue) begin
                        if (w_last_addr) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_addr <= r_addr + NEW_FEATURE_ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_last_hs) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_addr  <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld <= '0;
        end else begin
            r_rd_vld[0] <= w_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rd_vld[i] <= r_rd_vld[i-1];
            end
        end
    end

    // Output register reloads in the same cycle its beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bytes_left <= '0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
            r_tlast      <= 1'b0;
            r_tvalid     <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_bytes_left <= LEFT_W'(NEW_FEATURE_DEPTH);
            end else if (w_load) begin
                r_bytes_left <= r_bytes_left - LEFT_W'(w_pop_req);
            end

            if (w_load) begin
                r_tdata  <= w_beat_data;
                r_tkeep  <= w_beat_keep;
                r_tlast  <= (r_bytes_left == LEFT_W'(w_pop_req));
                r_tvalid <= 1'b1;
            end else if (r_tvalid && m_axis_tready) begin
                r_tdata  <= '0;
                r_tkeep  <= '0;
                r_tlast  <= 1'b0;
                r_tvalid <= 1'b0;
            end
        end
    end

    assign feat_bram_addrb = r_addr;
    assign m_axis_tdata    = r_tdata;
    assign m_axis_tkeep    = r_tkeep;
    assign m_axis_tlast    = r_tlast;
    assign m_axis_tvalid   = r_tvalid;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_gat_feat_stream_out.sv
// Self-checking bench for gat_feat_stream_out: four instances (depths 8, 10,
// 16 and depth 8 with two-cycle BRAM latency) against a beat-list model.
module tb_gat_feat_stream_out;

    localparam int N_INST = 4;
    localparam int FIFO_D = 8;

    function automatic int inst_ns(input int g);
        return (g == 2) ? 4 : 2;
    endfunction

    function automatic int inst_nf(input int g);
        return (g == 1) ? 5 : 4;
    endfunction

    function automatic int inst_lat(input int g);
        return (g == 3) ? 2 : 1;
    endfunction

    function automatic int inst_depth(input int g);
        return inst_ns(g) * inst_nf(g);
    endfunction

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_s  [N_INST];
    logic        tready_s [N_INST];
    logic [31:0] tdata_m  [N_INST];
    logic [3:0]  tkeep_m  [N_INST];
    logic        tlast_m  [N_INST];
    logic        tvalid_m [N_INST];
    logic        busy_m   [N_INST];
    logic        done_m   [N_INST];
    int          addr_m   [N_INST];
    logic [7:0]  bram     [N_INST][16];

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_INST; g++) begin : g_inst
        localparam int DEPTH = inst_depth(g);
        localparam int AW    = $clog2(DEPTH);
        localparam int LAT   = inst_lat(g);

        logic [AW-1:0] addrb;
        logic [7:0]    rd_pipe [LAT];

        always @(posedge clk) begin
            rd_pipe[0] <= bram[g][addrb];
            for (int i = 1; i < LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end

        assign addr_m[g] = int'(addrb);

        gat_feat_stream_out #(
            .DATA_WIDTH      (8),
            .NUM_SUBGRAPHS   (inst_ns(g)),
            .NUM_FEATURE_OUT (inst_nf(g)),
            .RD_LATENCY      (LAT),
            .FIFO_DEPTH      (FIFO_D),
            .AXIS_W          (32)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .start           (start_s[g]),
            .feat_bram_addrb (addrb),
            .feat_bram_dout  (rd_pipe[LAT-1]),
            .m_axis_tdata    (tdata_m[g]),
            .m_axis_tkeep    (tkeep_m[g]),
            .m_axis_tlast    (tlast_m[g]),
            .m_axis_tvalid   (tvalid_m[g]),
            .m_axis_tready   (tready_s[g]),
            .busy            (busy_m[g]),
            .done            (done_m[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected stream: byte k of beat n is feature 4n+k; bytes past the end are 0.
    function automatic void build_expected(input int g);
        int depth = inst_depth(g);
        int nb    = (depth + 3) / 4;
        exp_q.delete();
        for (int n = 0; n < nb; n++) begin
            beat_t b;
            b.data = '0;
            b.keep = '0;
            for (int k = 0; k < 4; k++) begin
                if (4*n + k < depth) begin
                    b.data[8*k +: 8] = bram[g][4*n + k];
                    b.keep[k]        = 1'b1;
                end
            end
            b.last = (n == nb - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic run_sweep(input int g, input bit rand_ready, input int stall0,
                             input bit restart, input int stall_addr);
        int    depth     = inst_depth(g);
        int    lat       = inst_lat(g);
        int    k         = 0;
        int    stall_cnt = 0;
        bit    seen_valid = 0;
        bit    pend      = 0;
        bit    got_last  = 0;
        bit    finished  = 0;
        bit    r;
        beat_t held;
        beat_t e;

        build_expected(g);
        @(negedge clk);
        start_s[g]  = 1'b1;
        tready_s[g] = 1'b0;
        while (k < 3000 && !finished) begin
            @(negedge clk);
            if (k == 0) begin
                start_s[g] = 1'b0;
                check($sformatf("busy_after_start_i%0d", g), busy_m[g], 1);
            end
            if (restart && k == 2) start_s[g] = 1'b1;
            if (restart && k == 3) start_s[g] = 1'b0;
            check($sformatf("addrb_in_range_i%0d", g), addr_m[g] < depth, 1);
            if (pend) begin
                check("held_tvalid", tvalid_m[g], 1);
                check("held_tdata", tdata_m[g], held.data);
                check("held_tkeep", tkeep_m[g], held.keep);
                check("held_tlast", tlast_m[g], held.last);
            end
            if (tvalid_m[g] && !seen_valid) begin
                seen_valid = 1;
                check($sformatf("first_tvalid_latency_i%0d", g), k, lat + 5);
            end
            if (stall_addr >= 0 && k == stall0 - 1) begin
                check("addrb_stalled", addr_m[g], stall_addr);
            end
            if (got_last) begin
                check($sformatf("done_pulse_i%0d", g), done_m[g], 1);
                check("busy_in_done", busy_m[g], 0);
                finished = 1;
            end else begin
                check("done_not_early", done_m[g], 0);
                if (k < stall0) begin
                    r = 1'b0;
                end else if (rand_ready) begin
                    if (stall_cnt > 0) begin
                        r = 1'b0;
                        stall_cnt--;
                    end else if ($urandom_range(0, 4) == 0) begin
                        r = 1'b0;
                        stall_cnt = 2;
                    end else begin
                        r = !tready_s[g];
                    end
                end else begin
                    r = 1'b1;
                end
                tready_s[g] = r;
                if (tvalid_m[g] && r) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("beat_tdata_i%0d", g), tdata_m[g], e.data);
                        check($sformatf("beat_tkeep_i%0d", g), tkeep_m[g], e.keep);
                        check($sformatf("beat_tlast_i%0d", g), tlast_m[g], e.last);
                        if (e.last) got_last = 1;
                    end
                    pend = 0;
                end else if (tvalid_m[g]) begin
                    pend      = 1;
                    held.data = tdata_m[g];
                    held.keep = tkeep_m[g];
                    held.last = tlast_m[g];
                end else begin
                    pend = 0;
                end
                k++;
            end
        end
        check($sformatf("sweep_complete_i%0d", g), finished, 1);
        tready_s[g] = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done_m[g], 0);
        check("addrb_back_to_0", addr_m[g], 0);
        check("beats_remaining", exp_q.size(), 0);
    endtask

    initial begin
        for (int g = 0; g < N_INST; g++) begin
            start_s[g]  = 1'b0;
            tready_s[g] = 1'b0;
            for (int i = 0; i < 16; i++) begin
                case (g)
                    1:       bram[g][i] = 8'hA0 + 8'(i);
                    2:       bram[g][i] = 8'($urandom);
                    default: bram[g][i] = 8'(i + 1);
                endcase
            end
        end

        repeat (3) @(negedge clk);
        for (int g = 0; g < N_INST; g++) begin
            check("rst_tvalid", tvalid_m[g], 0);
            check("rst_tlast", tlast_m[g], 0);
            check("rst_tdata", tdata_m[g], 0);
            check("rst_tkeep", tkeep_m[g], 0);
            check("rst_busy", busy_m[g], 0);
            check("rst_done", done_m[g], 0);
            check("rst_addrb", addr_m[g], 0);
        end
        rst_n = 1'b1;

        // Depth 8, ready held high.
        run_sweep(0, 0, 0, 0, -1);
        // Depth 10, partial last beat.
        run_sweep(1, 0, 0, 0, -1);
        // Depth 16, toggling ready with random stalls.
        run_sweep(2, 1, 0, 0, -1);
        // Depth 16, 50-cycle stall: one held beat plus a full FIFO of reads.
        run_sweep(2, 0, 50, 0, 4 + FIFO_D);
        // Extra start during FETCH, then a fresh sweep after done.
        run_sweep(0, 0, 0, 1, -1);
        run_sweep(0, 0, 0, 0, -1);

        // Abort mid-DRAIN with reset, then sweep again.
        @(negedge clk);
        tready_s[0] = 1'b0;
        start_s[0]  = 1'b1;
        @(negedge clk);
        start_s[0]  = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_reset_tvalid", tvalid_m[0], 1);
        check("pre_reset_busy", busy_m[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_tvalid", tvalid_m[0], 0);
        check("abort_tlast", tlast_m[0], 0);
        check("abort_busy", busy_m[0], 0);
        check("abort_done", done_m[0], 0);
        check("abort_addrb", addr_m[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, 0, 0, 0, -1);

        // Two-cycle BRAM latency, steady and stalled.
        run_sweep(3, 0, 0, 0, -1);
        run_sweep(3, 1, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
